rv_wb_timer: RTL and testbench
==============================

RV_WB_TIMER -- requirements
Module: rv_wb_timer

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, 32'h0200_0000, base of the 32-byte register window; PRESCALE_W, 16, prescaler width.
REQ-002 Ports SHALL be:
- i_clk  in  1  sole clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_wb_adr  in  32  byte address.
- i_wb_dat  in  32  write data.
- o_wb_dat  out  32  read data.
- i_wb_we  in  1  write enable.
- i_wb_sel  in  4  byte lane selects.
- i_wb_stb  in  1  strobe.
- i_wb_cyc  in  1  cycle.
- o_wb_ack  out  1  transfer acknowledge.
- o_irq  out  1  timer interrupt, level.
REQ-003 Everything SHALL be synchronous to i_clk rising edge, except the asynchronous reset assertion.

Function
REQ-004 The block SHALL decode a hit as i_wb_cyc & i_wb_stb & (i_wb_adr[31:5] == BASE_ADDR[31:5]); the register offset is i_wb_adr[4:2], and i_wb_adr[1:0] is ignored.
REQ-005 The handshake FSM SHALL have two states, IDLE and ACK:
- IDLE -> ACK on a hit.
- ACK -> IDLE unconditionally.
- o_wb_ack = 1 only in ACK.
- Consequences: one ack per transfer, 1-cycle latency, minimum 2 cycles per transfer, so a master holding stb/cyc high permanently is served correctly.
REQ-006 A non-hit SHALL produce no ack and no register side effect, leaving the bus to another responder.
REQ-007 Writes SHALL commit at the clock edge that ends the IDLE hit cycle; only the byte lanes with i_wb_sel[n]=1 are updated.
REQ-008 Read data SHALL be captured at that same edge into a register. o_wb_dat SHALL be valid while o_wb_ack=1 and SHALL be 0 otherwise.
REQ-009 Register map (offset : name : access):
- 0x00 : MTIME_LO : RW.
- 0x04 : MTIME_HI : RW.
- 0x08 : MTIMECMP_LO : RW.
- 0x0C : MTIMECMP_HI : RW.
- 0x10 : CTRL : RW; bit0 EN, bit1 IRQ_EN, others read 0.
- 0x14 : PRESCALE : RW; [PRESCALE_W-1:0], upper bits read 0.
- 0x18 : STATUS : RO; bit0 = (mtime >= mtimecmp).
- 0x1C : reserved.
REQ-010 Reserved offsets and writes to STATUS SHALL be acked, read 0, and have no effect on any register.
REQ-011 A read of MTIME_LO SHALL latch mtime[63:32] into a shadow register; a read of MTIME_HI SHALL return the shadow, not live mtime.
REQ-012 The prescaler counter pcnt SHALL behave as follows:
- While EN=1, pcnt counts up; when pcnt == PRESCALE, pcnt wraps to 0 and mtime increments by 1.
- PRESCALE=0 means an increment every cycle.
- While EN=0, pcnt and mtime hold.
REQ-013 mtime SHALL be 64-bit unsigned and wrap from all-ones to 0 without flag or interrupt side effect.
REQ-014 A bus write to MTIME_LO or MTIME_HI SHALL take priority over a same-cycle increment: the written lanes take the write value, the unwritten half holds, and no carry is applied that cycle.
REQ-015 A write to PRESCALE or CTRL SHALL reset pcnt to 0.
REQ-016 o_irq SHALL be registered, equal to IRQ_EN & (mtime >= mtimecmp) evaluated on the register values at the previous clock edge, i.e. one cycle behind.
REQ-017 The comparison SHALL be a full 64-bit unsigned compare.

Reset
REQ-018 On i_reset_n=0, asynchronously:
- FSM = IDLE, o_wb_ack=0, o_wb_dat=0, o_irq=0.
- mtime=0, shadow=0, pcnt=0.
- mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0.
REQ-019 Reset asserted while in ACK SHALL drop o_wb_ack immediately; after release the FSM starts in IDLE and no pending transfer is completed.

Verification
REQ-020 Read of reserved 0x1C with stb/cyc held high -> ack pulses 1 cycle after the hit, low the next cycle, o_wb_dat=0 during ack; repeats every 2 cycles.
REQ-021 Write 32'hAABBCCDD to MTIMECMP_LO with sel=4'b0101 after reset -> readback 32'hFFBBFFDD.
REQ-022 PRESCALE=3, CTRL=1, hold 40 cycles idle -> MTIME_LO reads 10 (+/-1 for the access cycle); with EN=0 the value is frozen across 20 cycles.
REQ-023 mtime=64'h0000_0000_FFFF_FFFF, EN=1, PRESCALE=0 -> MTIME_LO read returns a value in 0..3 and MTIME_HI read returns 1; write MTIME_HI while also reading MTIME_LO -> shadow unaffected by the later write.
REQ-024 mtimecmp=20, CTRL=3, PRESCALE=0 -> o_irq rises exactly 1 cycle after mtime reaches 20; STATUS bit0=1; writing mtimecmp=64'hFFFF_FFFF_FFFF_FFFF clears o_irq the following cycle.
REQ-025 Non-matching address 32'h1000_0000 with stb high for 10 cycles -> o_wb_ack stays 0 and no register changes; reset pulse during ACK -> ack=0 same cycle and all registers at their reset values.

Source files
------------

// File: rtl/rv_wb_timer.sv
// RISC-V style machine timer (mtime/mtimecmp) behind a Wishbone classic slave.
// One ack per transfer, one-cycle latency; prescaled 64-bit counter and level irq.
module rv_wb_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_stb,
  input  logic        i_wb_cyc,
  output logic        o_wb_ack,
  output logic        o_irq
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;
  localparam logic [2:0] OFF_PRESCALE    = 3'd5;
  localparam logic [2:0] OFF_STATUS      = 3'd6;

  state_t                state_reg;
  logic [31:0]           dat_reg;
  logic [63:0]           mtime_reg;
  logic [63:0]           mtimecmp_reg;
  logic [31:0]           shadow_reg;
  logic [1:0]            ctrl_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [PRESCALE_W-1:0] pcnt_reg;
  logic                  irq_reg;

  logic        hit, acc, wr, rd;
  logic [2:0]  off;
  logic [31:0] wmask;
  logic [31:0] rd_data;
  logic        cmp_ge, pcnt_clr, tick;
  logic        unused_adr;

  assign hit = i_wb_cyc & i_wb_stb & (i_wb_adr[31:5] == BASE_ADDR[31:5]);
  // Only a hit seen in IDLE is a transfer; the ACK cycle never has side effects.
  assign acc = hit & (state_reg == IDLE);
  assign wr  = acc & i_wb_we;
  assign rd  = acc & ~i_wb_we;
  assign off = i_wb_adr[4:2];
  assign unused_adr = ^i_wb_adr[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[8*gi +: 8] = {8{i_wb_sel[gi]}};
    end
  endgenerate

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign cmp_ge   = (mtime_reg >= mtimecmp_reg);
  assign pcnt_clr = wr & ((off == OFF_CTRL) | (off == OFF_PRESCALE));
  assign tick     = ctrl_reg[0] & (pcnt_reg == prescale_reg) & ~pcnt_clr;

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_MTIME_LO:    rd_data = mtime_reg[31:0];
      OFF_MTIME_HI:    rd_data = shadow_reg;
      OFF_MTIMECMP_LO: rd_data = mtimecmp_reg[31:0];
      OFF_MTIMECMP_HI: rd_data = mtimecmp_reg[63:32];
      OFF_CTRL:        rd_data = {30'd0, ctrl_reg};
      OFF_PRESCALE:    rd_data = 32'(prescale_reg);
      OFF_STATUS:      rd_data = {31'd0, cmp_ge};
      default:         rd_data = '0;
    endcase
  end

  // Bus handshake and read path
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg  <= IDLE;
      dat_reg    <= '0;
      shadow_reg <= '0;
    end else begin
      case (state_reg)
        IDLE:    if (hit) state_reg <= ACK;
        ACK:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      dat_reg <= rd ? rd_data : '0;
      if (rd && off == OFF_MTIME_LO)
        shadow_reg <= mtime_reg[63:32];
    end
  end

  // Timer registers; bus writes to mtime win over the prescaled increment.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mtime_reg    <= '0;
      mtimecmp_reg <= '1;
      ctrl_reg     <= '0;
      prescale_reg <= '0;
      pcnt_reg     <= '0;
      irq_reg      <= 1'b0;
    end else begin
      if (wr && off == OFF_MTIME_LO)
        mtime_reg[31:0] <= merge(mtime_reg[31:0], i_wb_dat, wmask);
      else if (wr && off == OFF_MTIME_HI)
        mtime_reg[63:32] <= merge(mtime_reg[63:32], i_wb_dat, wmask);
      else if (tick)
        mtime_reg <= mtime_reg + 64'd1;

      if (wr && off == OFF_MTIMECMP_LO)
        mtimecmp_reg[31:0] <= merge(mtimecmp_reg[31:0], i_wb_dat, wmask);
      if (wr && off == OFF_MTIMECMP_HI)
        mtimecmp_reg[63:32] <= merge(mtimecmp_reg[63:32], i_wb_dat, wmask);
      if (wr && off == OFF_CTRL && i_wb_sel[0])
        ctrl_reg <= i_wb_dat[1:0];
      if (wr && off == OFF_PRESCALE)
        prescale_reg <= (prescale_reg & ~wmask[PRESCALE_W-1:0]) |
                        (i_wb_dat[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);

      if (pcnt_clr)
        pcnt_reg <= '0;
      else if (ctrl_reg[0])
        pcnt_reg <= (pcnt_reg == prescale_reg) ? '0 : pcnt_reg + 1'b1;

      irq_reg <= ctrl_reg[1] & cmp_ge;
    end
  end

  assign o_wb_ack = (state_reg == ACK);
  assign o_wb_dat = dat_reg;
  assign o_irq    = irq_reg;

endmodule

// File: tb/tb_rv_wb_timer.sv
// Directed bench for rv_wb_timer: read expectations go through a scoreboard
// queue and are popped when the ack arrives.
module tb_rv_wb_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [4:0] A_MLO = 5'h00, A_MHI = 5'h04, A_CLO = 5'h08, A_CHI = 5'h0C;
  localparam logic [4:0] A_CTRL = 5'h10, A_PRE = 5'h14, A_STAT = 5'h18, A_RSVD = 5'h1C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0, wdat = '0, rdat;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0, ack, irq;
  logic [3:0]  sel = 4'h0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  rv_wb_timer dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat),
    .i_wb_we(we), .i_wb_sel(sel), .i_wb_stb(stb), .i_wb_cyc(cyc),
    .o_wb_ack(ack), .o_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input logic [31:0] obs,
                           input logic [31:0] lo, input logic [31:0] hi);
    vectors++;
    assert (obs >= lo && obs <= hi) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wb_xfer(input logic [4:0] off, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q);
    int n;
    @(posedge clk); #1;
    adr = BASE | 32'(off); we = w; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ack !== 1'b1 && n < 8);
    q = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("ack_latency", (ack === 1'b1) ? 64'(n) : 64'd99, 64'd1);
  endtask

  task automatic wb_write(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    wb_xfer(off, 1'b1, d, s, q);
  endtask

  task automatic wb_read_raw(input logic [4:0] off, output logic [31:0] q);
    wb_xfer(off, 1'b0, 32'h0, 4'hF, q);
  endtask

  task automatic wb_read(input logic [4:0] off, input logic [31:0] exp, input string tag);
    sb_t e;
    logic [31:0] q;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    wb_xfer(off, 1'b0, 32'h0, 4'hF, q);
    e = sb_q.pop_front();
    chk(e.tag, 64'(q), 64'(e.exp));
  endtask

  initial begin
    logic [31:0] q;
    int first_k;

    // Reset state
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_irq", irq, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    wb_read(A_MLO, 32'h0, "rst_mtime_lo");
    wb_read(A_MHI, 32'h0, "rst_mtime_hi");
    wb_read(A_CLO, 32'hFFFF_FFFF, "rst_cmp_lo");
    wb_read(A_CHI, 32'hFFFF_FFFF, "rst_cmp_hi");
    wb_read(A_CTRL, 32'h0, "rst_ctrl");
    wb_read(A_PRE, 32'h0, "rst_prescale");
    wb_read(A_STAT, 32'h0, "rst_status");

    // Byte-lane write
    wb_write(A_CLO, 32'hAABB_CCDD, 4'b0101);
    wb_read(A_CLO, 32'hFFBB_FFDD, "sel_merge");

    // Reserved offset with stb/cyc held high: ack every other cycle, data 0
    @(posedge clk); #1;
    adr = BASE | 32'h1C; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("hold_ack", ack, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("hold_dat", rdat, 0);
    end
    stb = 1'b0; cyc = 1'b0;

    // Status and reserved are write-ignored
    wb_write(A_STAT, 32'hFFFF_FFFF, 4'hF);
    wb_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
    wb_read(A_STAT, 32'h0, "status_ro");
    wb_read(A_RSVD, 32'h0, "rsvd_zero");
    wb_read(A_CTRL, 32'h0, "rsvd_no_ctrl");

    // Non-matching address: no ack, no side effect
    @(posedge clk); #1;
    adr = 32'h1000_0000; we = 1'b1; wdat = 32'h1234_5678; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("nohit_ack", ack, 0);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    wb_read(A_MLO, 32'h0, "nohit_mtime_lo");
    wb_read(A_CLO, 32'hFFBB_FFDD, "nohit_cmp_lo");

    // Prescale 3: one tick per 4 cycles
    wb_write(A_PRE, 32'h3, 4'hF);
    wb_read(A_PRE, 32'h3, "prescale_rb");
    wb_write(A_CTRL, 32'h1, 4'hF);
    repeat (40) @(posedge clk);
    wb_read_raw(A_MLO, q);
    chk_range("prescale_count", q, 9, 11);

    // EN=0 freezes mtime
    wb_write(A_CTRL, 32'h0, 4'hF);
    wb_write(A_MLO, 32'h55, 4'hF);
    wb_write(A_MHI, 32'h0, 4'hF);
    repeat (20) @(posedge clk);
    wb_read(A_MLO, 32'h55, "frozen_lo");
    wb_read(A_MHI, 32'h0, "frozen_hi");

    // Carry into the high word and shadow behaviour
    wb_write(A_MLO, 32'hFFFF_FFFF, 4'hF);
    wb_write(A_MHI, 32'h0, 4'hF);
    wb_write(A_PRE, 32'h0, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    wb_read_raw(A_MLO, q);
    chk_range("carry_lo", q, 0, 3);
    wb_read(A_MHI, 32'h1, "carry_hi");
    wb_read_raw(A_MLO, q);
    wb_write(A_MHI, 32'hDEAD_0000, 4'hF);
    wb_read(A_MHI, 32'h1, "shadow_hold");
    wb_read_raw(A_MLO, q);
    wb_read(A_MHI, 32'hDEAD_0000, "shadow_new");

    // Interrupt timing against mtimecmp = 20
    wb_write(A_CTRL, 32'h0, 4'hF);
    wb_write(A_MLO, 32'h0, 4'hF);
    wb_write(A_MHI, 32'h0, 4'hF);
    wb_write(A_CHI, 32'h0, 4'hF);
    wb_write(A_CLO, 32'd20, 4'hF);
    wb_write(A_CTRL, 32'h3, 4'hF);
    chk("irq_pre", irq, 0);
    first_k = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin
        first_k = k;
        break;
      end
    end
    chk("irq_rise_cycle", 64'(first_k), 64'd21);
    wb_read(A_STAT, 32'h1, "status_ge");
    wb_read(A_CTRL, 32'h3, "ctrl_rb");
    wb_write(A_CHI, 32'hFFFF_FFFF, 4'hF);
    chk("irq_hold", irq, 1);
    @(posedge clk); #1;
    chk("irq_clear", irq, 0);
    wb_write(A_CLO, 32'hFFFF_FFFF, 4'hF);
    wb_read(A_STAT, 32'h0, "status_lt");

    // Reset asserted in the middle of an ACK cycle
    @(posedge clk); #1;
    adr = BASE | 32'(A_CHI); we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    chk("ack_before_rst", ack, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_dat", rdat, 0);
    stb = 1'b0; cyc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack", ack, 0);
    wb_read(A_MLO, 32'h0, "post_rst_mtime_lo");
    wb_read(A_MHI, 32'h0, "post_rst_mtime_hi");
    wb_read(A_CLO, 32'hFFFF_FFFF, "post_rst_cmp_lo");
    wb_read(A_CHI, 32'hFFFF_FFFF, "post_rst_cmp_hi");
    wb_read(A_CTRL, 32'h0, "post_rst_ctrl");
    wb_read(A_PRE, 32'h0, "post_rst_prescale");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
